fp_normalize: RTL
=================

FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL provide ports, clock and reset first: clk  in  1  sole clock; rstn  in  1  asynchronous active-low reset.
REQ-002 SHALL provide: in_valid  in  1  raw result offered by the adder datapath.
REQ-003 SHALL provide: in_ready  out  1  block can accept; high only in IDLE.
REQ-004 SHALL provide: in_sign  in  1  result sign.
REQ-005 SHALL provide: in_exp  in  8  biased exponent of the larger operand.
REQ-006 SHALL provide: in_mant  in  28  bit 27 carry, bit 26 hidden, bits 25:3 fraction, bit 2 guard, bit 1 round, bit 0 sticky.
REQ-007 SHALL provide: out_valid  out  1  packed result available.
REQ-008 SHALL provide: out_ready  in  1  consumer accepts the result.
REQ-009 SHALL provide: out_result  out  32  IEEE-754 single word {sign, exp[7:0], frac[22:0]}.
REQ-010 SHALL provide: out_overflow  out  1  and out_underflow  out  1, flags valid with out_valid.
REQ-011 SHALL use one clock, clk; reset rstn is asynchronous and active-low.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, OUT.
REQ-013 IDLE, in_valid high: capture the inputs and go to NORM; if in_mant[27]=1, right-shift the mantissa one place, OR the lost bit into sticky and add 1 to exp at capture.
REQ-014 NORM, each cycle: if mant[26]=1 or mant=0 go to ROUND; else if exp=1 flush to zero (+0 with in_sign, out_underflow=1) and go to ROUND; else shift mant left 1 and subtract 1 from exp.
REQ-015 mant=0 at ROUND SHALL produce 0x00000000, sign forced 0, with no flags set.
REQ-016 ROUND SHALL apply the rounding rule of REQ-025/026; a mantissa carry-out SHALL right-shift it one place and add 1 to exp; go to OUT.
REQ-017 Internal exponent SHALL be 10-bit signed; exp>=255 after rounding, or in_exp=255 at capture, SHALL give {sign,8'hFF,23'h0} with out_overflow=1.
REQ-018 OUT: out_valid=1; out_result and flags held stable until out_valid and out_ready are both high, then return to IDLE.
REQ-019 Latency from the accept edge to out_valid SHALL be k+2 cycles, where k is the number of left shifts (0..26); maximum 28.
REQ-020 in_ready SHALL be low in NORM, ROUND and OUT; no pipelining, one operation in flight.
REQ-021 in_valid while busy SHALL be ignored; the producer holds it until in_ready.

Reset
REQ-022 On rstn low, immediately: state=IDLE, out_valid=0, out_result=0, out_overflow=0, out_underflow=0.
REQ-023 On rstn low, in_ready=1 once reset is released.
REQ-024 Reset in any state SHALL discard the in-flight operation; no partial result is emitted.

Configuration
REQ-025 With FP_NORM_RNE_EN defined: round to nearest even; increment when G & (R | S | LSB).
REQ-026 Without FP_NORM_RNE_EN: truncate, discard G/R/S; ROUND still takes one cycle so latency is unchanged.

Structure
REQ-027 Package fp_pkg SHALL hold EXP_BIAS=127, EXP_MAX=8'hFF, FRAC_W=23, MANT_W=28, typedef fp32_t packed struct, and typedef norm_state_t enum.
REQ-028 Combinational rounding plus overflow packing SHALL be sub-module fp_round, instantiated once.

Verification
REQ-029 in_exp=127, in_mant=28'h8000000, sign 0 -> out_result=0x40000000 after 2 cycles, no flags.
REQ-030 in_exp=127, in_mant=28'h0000008 -> out_result=0x34000000 after 25 cycles (k=23).
REQ-031 in_exp=127, in_mant=28'h400000C -> with the macro 0x3F800002, without it 0x3F800001; in_mant=28'h4000004 -> 0x3F800000 in both builds.
REQ-032 in_exp=254, in_mant=28'h8000000 -> 0x7F800000, out_overflow=1; in_exp=1, in_mant=28'h2000000 -> 0x00000000, out_underflow=1.
REQ-033 out_ready low for 5 cycles in OUT -> out_result stable, in_ready=0, and a second in_valid is not accepted until the handshake completes.
REQ-034 rstn pulsed low during NORM of the REQ-030 case -> out_valid never rises for it; the next operation completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision normalise/round block.
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam int          FRAC_W   = 23;
  localparam int          MANT_W   = 28;
  localparam int          EXP_W    = 10;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } norm_state_t;

  function automatic fp32_t fp_inf(input logic sign);
    fp32_t r;
    r.sign = sign;
    r.exp  = EXP_MAX;
    r.frac = '0;
    return r;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding and IEEE-754 packing, including overflow saturation.
// FP_NORM_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_round
  import fp_pkg::*;
(
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp,
  input  logic [MANT_W-1:0]       mant,
  input  logic                    ovf_in,
  input  logic                    uflow_in,
  output logic [31:0]             result,
  output logic                    overflow,
  output logic                    underflow
);

  logic                    inc;
  logic [24:0]             sum;
  logic [FRAC_W-1:0]       frac;
  logic signed [EXP_W-1:0] exp_r;
  fp32_t                   packed_res;
  logic                    unused_bits;

`ifdef FP_NORM_RNE_EN
  assign inc         = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign unused_bits = mant[27];
`else
  assign inc         = 1'b0;
  assign unused_bits = ^{mant[27], mant[2:0]};
`endif

  always_comb begin
    sum = {1'b0, mant[26:3]} + {24'd0, inc};
    // Rounding carry-out renormalises by one place.
    if (sum[24]) begin
      frac  = sum[23:1];
      exp_r = exp + 10'sd1;
    end else begin
      frac  = sum[22:0];
      exp_r = exp;
    end
  end

  always_comb begin
    packed_res.sign = sign;
    packed_res.exp  = exp_r[7:0];
    packed_res.frac = frac;
    overflow        = 1'b0;
    underflow       = uflow_in;
    if (mant == '0) begin
      packed_res = '0;
    end else if (ovf_in || (exp_r >= 10'sd255)) begin
      packed_res = fp_inf(sign);
      overflow   = 1'b1;
    end
  end

  assign result = packed_res;

endmodule

// File: rtl/fp_normalize.sv
// Multi-cycle normaliser for an adder's raw result: one-bit-per-cycle left shift,
// then a rounding cycle. FP_NORM_RNE_EN enables round-to-nearest-even in fp_round.
module fp_normalize
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  norm_state_t             state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic                    ovf_q, ovf_d;
  logic                    uflow_q, uflow_d;
  logic [31:0]             result_q, result_d;
  logic                    res_ovf_q, res_ovf_d;
  logic                    res_uflow_q, res_uflow_d;

  logic [31:0]             rnd_result;
  logic                    rnd_ovf;
  logic                    rnd_uflow;
  logic                    norm_done;

  fp_round u_round (
    .sign      (sign_q),
    .exp       (exp_q),
    .mant      (mant_q),
    .ovf_in    (ovf_q),
    .uflow_in  (uflow_q),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_uflow)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      ovf_q       <= 1'b0;
      uflow_q     <= 1'b0;
      result_q    <= '0;
      res_ovf_q   <= 1'b0;
      res_uflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      ovf_q       <= ovf_d;
      uflow_q     <= uflow_d;
      result_q    <= result_d;
      res_ovf_q   <= res_ovf_d;
      res_uflow_q <= res_uflow_d;
    end
  end

  assign norm_done = mant_q[26] || (mant_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = NORM;
      NORM:    if (norm_done || (exp_q <= 10'sd1)) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    ovf_d       = ovf_q;
    uflow_d     = uflow_q;
    result_d    = result_q;
    res_ovf_d   = res_ovf_q;
    res_uflow_d = res_uflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          ovf_d   = (in_exp == EXP_MAX);
          uflow_d = 1'b0;
          // Adder carry: pre-shift right so the hidden bit sits at bit 26.
          if (in_mant[27]) begin
            mant_d = {1'b0, in_mant[27:2], in_mant[1] | in_mant[0]};
            exp_d  = $signed({2'b00, in_exp}) + 10'sd1;
          end else begin
            mant_d = in_mant;
            exp_d  = $signed({2'b00, in_exp});
          end
        end
      end
      NORM: begin
        if (!norm_done) begin
          if (exp_q <= 10'sd1) begin
            mant_d  = '0;
            uflow_d = 1'b1;
          end else begin
            mant_d = mant_q << 1;
            exp_d  = exp_q - 10'sd1;
          end
        end
      end
      ROUND: begin
        result_d    = rnd_result;
        res_ovf_d   = rnd_ovf;
        res_uflow_d = rnd_uflow;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == IDLE);
    out_valid     = (state_q == OUT);
    out_result    = result_q;
    out_overflow  = res_ovf_q;
    out_underflow = res_uflow_q;
  end

endmodule
